// File: rtl/pio_regs_mem_osr_if.sv
// pio_regs_mem_osr_if: single-cycle register bus between the system bus master and the PIO core
interface pio_regs_mem_osr_if;
    logic        sel;
    logic        RW;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    modport master (output sel, RW, addr, wdata, input rdata, busy);
    modport slave (input sel, RW, addr, wdata, output rdata, busy);
endinterface

// File: rtl/pio_regs_mem_osr.sv
// pio_regs_mem_osr: PIO register file, instruction memory and output shift register
module pio_regs_mem_osr #(
    parameter int OSR_WIDTH  = 8,
    parameter int IMEM_DEPTH = 32,
    localparam int AW = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_regs_mem_osr_if.slave    bus,
    input  logic [AW-1:0]        pc,
    input  logic                 rd,
    output logic [15:0]          imem_rdata,
    output logic                 sm_enable,
    output logic                 sm_restart,
    output logic [15:0]          clkdiv_int,
    output logic [7:0]           clkdiv_frac,
    output logic [4:0]           wrap_top,
    output logic [4:0]           wrap_bottom,
    output logic                 out_shiftdir,
    output logic                 instr_wr,
    input  logic                 osr_shift,
    input  logic [3:0]           osr_shift_amnt,
    output logic [OSR_WIDTH-1:0] osr_data,
    output logic [OSR_WIDTH-1:0] osr_valid
);
    localparam logic [11:0] A_CTRL      = 12'h000;
    localparam logic [11:0] A_TXF0      = 12'h010;
    localparam logic [11:0] A_IMEM      = 12'h048;
    localparam logic [11:0] A_IMEM_LAST = 12'(12'h048 + 4 * (IMEM_DEPTH - 1));
    localparam logic [11:0] A_CLKDIV    = 12'h0C8;
    localparam logic [11:0] A_EXEC      = 12'h0CC;
    localparam logic [11:0] A_SHIFT     = 12'h0D0;
    localparam logic [11:0] A_ADDR      = 12'h0D4;
    localparam logic [11:0] A_INSTR     = 12'h0D8;

    logic          wr;
    logic          rd_bus;
    logic          imem_we;
    logic [AW-1:0] imem_idx;
    logic          ctrl_en;
    logic [23:0]   clkdiv;
    logic [9:0]    execctrl;
    logic [1:0]    shiftctrl;
    logic [31:0]   reg_val;
    logic [15:0]   mem [IMEM_DEPTH];

    always_comb begin
        wr       = bus.sel & bus.RW;
        rd_bus   = bus.sel & ~bus.RW;
        imem_we  = wr && bus.addr >= A_IMEM && bus.addr <= A_IMEM_LAST;
        imem_idx = AW'((bus.addr - A_IMEM) >> 2);
        instr_wr = wr && bus.addr == A_INSTR;
        bus.busy = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en    <= 1'b0;
            sm_restart <= 1'b0;
            clkdiv     <= 24'h000100;
            execctrl   <= 10'h3E0;
            shiftctrl  <= 2'b11;
        end else begin
            sm_restart <= wr && bus.addr == A_CTRL && bus.wdata[4];
            if (wr && bus.addr == A_CTRL) ctrl_en <= bus.wdata[0];
            if (wr && bus.addr == A_CLKDIV) clkdiv <= bus.wdata[31:8];
            if (wr && bus.addr == A_EXEC) execctrl <= bus.wdata[16:7];
            if (wr && bus.addr == A_SHIFT) shiftctrl <= bus.wdata[19:18];
        end
    end

    // Array is deliberately not reset; a same-address fetch sees the pre-write word.
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_idx] <= bus.wdata[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) imem_rdata <= '0;
        else if (rd) imem_rdata <= mem[pc];
    end

    // A TXF0 load takes priority over a shift in the same cycle; shifts of OSR_WIDTH or more empty it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            osr_data  <= '0;
            osr_valid <= '0;
        end else if (wr && bus.addr == A_TXF0) begin
            osr_data  <= bus.wdata[OSR_WIDTH-1:0];
            osr_valid <= '1;
        end else if (osr_shift && osr_shift_amnt != 4'd0) begin
            osr_data  <= out_shiftdir ? osr_data >> osr_shift_amnt : osr_data << osr_shift_amnt;
            osr_valid <= out_shiftdir ? osr_valid >> osr_shift_amnt : osr_valid << osr_shift_amnt;
        end
    end

    always_comb begin
        reg_val = '0;
        case (bus.addr)
            A_CTRL:   reg_val = {31'b0, ctrl_en};
            A_CLKDIV: reg_val = {clkdiv, 8'b0};
            A_EXEC:   reg_val = {15'b0, execctrl, 7'b0};
            A_SHIFT:  reg_val = {12'b0, shiftctrl, 18'b0};
            A_ADDR:   reg_val = 32'(pc);
            default:  reg_val = '0;
        endcase
        bus.rdata = rd_bus ? reg_val : '0;
    end

    always_comb begin
        sm_enable    = ctrl_en;
        clkdiv_int   = clkdiv[23:8];
        clkdiv_frac  = clkdiv[7:0];
        wrap_top     = execctrl[9:5];
        wrap_bottom  = execctrl[4:0];
        out_shiftdir = shiftctrl[1];
    end
endmodule

// File: tb/tb_pio_regs_mem_osr.sv
// tb_pio_regs_mem_osr: randomized checks of the PIO register core against a behavioural model
module tb_pio_regs_mem_osr;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  pc = '0;
    logic        rd = 1'b0;
    logic [15:0] imem_rdata;
    logic        sm_enable, sm_restart, out_shiftdir, instr_wr;
    logic [15:0] clkdiv_int;
    logic [7:0]  clkdiv_frac;
    logic [4:0]  wrap_top, wrap_bottom;
    logic        osr_shift = 1'b0;
    logic [3:0]  osr_shift_amnt = '0;
    logic [7:0]  osr_data, osr_valid;
    int checks = 0;
    int failures = 0;

    pio_regs_mem_osr_if bus();

    pio_regs_mem_osr dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .pc(pc), .rd(rd),
        .imem_rdata(imem_rdata), .sm_enable(sm_enable), .sm_restart(sm_restart),
        .clkdiv_int(clkdiv_int), .clkdiv_frac(clkdiv_frac), .wrap_top(wrap_top),
        .wrap_bottom(wrap_bottom), .out_shiftdir(out_shiftdir), .instr_wr(instr_wr),
        .osr_shift(osr_shift), .osr_shift_amnt(osr_shift_amnt),
        .osr_data(osr_data), .osr_valid(osr_valid)
    );

    always #5 clk = ~clk;

    logic        m_en;
    logic [31:0] m_clkdiv, m_exec, m_shift;
    logic [15:0] m_mem [32];
    logic [7:0]  m_od, m_ov;

    task automatic model_reset;
        m_en = 1'b0;
        m_clkdiv = 32'h0001_0000;
        m_exec = 32'h0001_F000;
        m_shift = 32'h000C_0000;
        m_od = '0;
        m_ov = '0;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h000) m_en = d[0];
        if (a == 12'h010) begin m_od = d[7:0]; m_ov = 8'hFF; end
        if (a >= 12'h048 && a <= 12'h0C4) m_mem[(int'(a) - 'h48) / 4] = d[15:0];
        if (a == 12'h0C8) m_clkdiv = d & 32'hFFFF_FF00;
        if (a == 12'h0CC) m_exec = d & 32'h0001_FF80;
        if (a == 12'h0D0) m_shift = d & 32'h000C_0000;
    endtask

    task automatic model_shift(input int a);
        int f;
        if (a == 0) return;
        if (a >= 8) begin m_od = '0; m_ov = '0; return; end
        f = 1 << a;
        if (m_shift[19]) begin
            m_od = 8'(int'(m_od) / f);
            m_ov = 8'(int'(m_ov) / f);
        end else begin
            m_od = 8'((int'(m_od) * f) % 256);
            m_ov = 8'((int'(m_ov) * f) % 256);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [11:0] a);
        case (a)
            12'h000: return {31'b0, m_en};
            12'h0C8: return m_clkdiv;
            12'h0CC: return m_exec;
            12'h0D0: return m_shift;
            12'h0D4: return {27'b0, pc};
            default: return 32'h0;
        endcase
    endfunction

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.RW = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        model_write(a, d);
        @(negedge clk);
        bus.sel = 1'b0; bus.RW = 1'b0;
    endtask

    task automatic bus_rd(input logic [11:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.sel = 1'b1; bus.RW = 1'b0; bus.addr = a;
        #1 v = bus.rdata;
        bus.sel = 1'b0;
    endtask

    task automatic osr_cycle(input logic ld, input logic [31:0] d, input logic sh, input logic [3:0] a);
        @(negedge clk);
        if (ld) begin bus.sel = 1'b1; bus.RW = 1'b1; bus.addr = 12'h010; bus.wdata = d; end
        osr_shift = sh; osr_shift_amnt = a;
        @(posedge clk);
        if (ld) model_write(12'h010, d);
        else if (sh) model_shift(int'(a));
        @(negedge clk);
        bus.sel = 1'b0; bus.RW = 1'b0; osr_shift = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        bus_rd(12'h0C8, v);
        checks++; if (v !== 32'h0001_0000) begin failures++; $display("FAIL reset_clkdiv got=%h exp=%h", v, 32'h0001_0000); end
        bus_rd(12'h0CC, v);
        checks++; if (v !== 32'h0001_F000) begin failures++; $display("FAIL reset_execctrl got=%h exp=%h", v, 32'h0001_F000); end
        bus_rd(12'h0D0, v);
        checks++; if (v !== 32'h000C_0000) begin failures++; $display("FAIL reset_shiftctrl got=%h exp=%h", v, 32'h000C_0000); end
        checks++;
        if ({clkdiv_int, clkdiv_frac, wrap_top, wrap_bottom, out_shiftdir} !== {16'd1, 8'd0, 5'd31, 5'd0, 1'b1}) begin
            failures++; $display("FAIL reset_cfg_outputs got=%h exp=%h",
                {clkdiv_int, clkdiv_frac, wrap_top, wrap_bottom, out_shiftdir}, {16'd1, 8'd0, 5'd31, 5'd0, 1'b1});
        end
        checks++;
        if ({sm_enable, sm_restart, instr_wr, bus.busy, osr_data, osr_valid, imem_rdata} !== 36'h0) begin
            failures++; $display("FAIL reset_zero_outputs got=%h exp=0",
                {sm_enable, sm_restart, instr_wr, bus.busy, osr_data, osr_valid, imem_rdata});
        end
    endtask

    task automatic test_imem;
        logic [31:0] v;
        logic [15:0] exp, old, nw;
        int k;
        bus_wr(12'h054, 32'h0000_E081);
        @(negedge clk); pc = 5'd3; rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        checks++; if (imem_rdata !== 16'hE081) begin failures++; $display("FAIL imem_fetch3 got=%h exp=%h", imem_rdata, 16'hE081); end
        bus_rd(12'h054, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL imem_read_zero got=%h exp=0", v); end
        for (int i = 0; i < 32; i++) bus_wr(12'(12'h048 + 4 * i), $urandom);
        exp = imem_rdata;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); pc = 5'($urandom); rd = 1'($urandom);
            @(posedge clk);
            if (rd) exp = m_mem[pc];
            #1;
            checks++; if (imem_rdata !== exp) begin failures++; $display("FAIL imem_random pc=%0d rd=%0b got=%h exp=%h", pc, rd, imem_rdata, exp); end
        end
        k = $urandom_range(0, 31);
        old = m_mem[k];
        nw = ~old;
        @(negedge clk);
        bus.sel = 1'b1; bus.RW = 1'b1; bus.addr = 12'(12'h048 + 4 * k); bus.wdata = {16'h0, nw};
        pc = 5'(k); rd = 1'b1;
        @(posedge clk);
        model_write(bus.addr, bus.wdata);
        #1;
        checks++; if (imem_rdata !== old) begin failures++; $display("FAIL imem_same_addr_old got=%h exp=%h", imem_rdata, old); end
        @(negedge clk); bus.sel = 1'b0; bus.RW = 1'b0;
        @(posedge clk); #1;
        checks++; if (imem_rdata !== nw) begin failures++; $display("FAIL imem_same_addr_new got=%h exp=%h", imem_rdata, nw); end
        rd = 1'b0;
    endtask

    task automatic test_ctrl;
        logic [31:0] v;
        bus_wr(12'h000, 32'h11);
        checks++; if ({sm_enable, sm_restart} !== 2'b11) begin failures++; $display("FAIL ctrl_enable_restart got=%b exp=11", {sm_enable, sm_restart}); end
        bus_rd(12'h000, v);
        checks++; if (sm_restart !== 1'b0) begin failures++; $display("FAIL ctrl_restart_one_cycle got=%b exp=0", sm_restart); end
        checks++; if (v !== 32'h1) begin failures++; $display("FAIL ctrl_read got=%h exp=1", v); end
        bus_wr(12'h000, 32'h10);
        checks++; if ({sm_enable, sm_restart} !== 2'b01) begin failures++; $display("FAIL ctrl_disable_restart got=%b exp=01", {sm_enable, sm_restart}); end
        bus_rd(12'h000, v);
        checks++; if (v !== exp_read(12'h000) || sm_restart !== 1'b0) begin failures++; $display("FAIL ctrl_read_disabled got=%h/%b exp=0/0", v, sm_restart); end
    endtask

    task automatic test_osr;
        logic [31:0] v;
        bus_wr(12'h0D0, 32'h000C_0000);
        bus_wr(12'h010, 32'hA5);
        checks++; if ({osr_data, osr_valid} !== 16'hA5FF) begin failures++; $display("FAIL osr_load got=%h exp=A5FF", {osr_data, osr_valid}); end
        osr_cycle(1'b0, 32'h0, 1'b1, 4'd1);
        checks++; if ({osr_data, osr_valid} !== 16'h527F) begin failures++; $display("FAIL osr_shift_right1 got=%h exp=527F", {osr_data, osr_valid}); end
        osr_cycle(1'b0, 32'h0, 1'b1, 4'd9);
        checks++; if ({osr_data, osr_valid} !== 16'h0000) begin failures++; $display("FAIL osr_shift9_clear got=%h exp=0000", {osr_data, osr_valid}); end
        bus_rd(12'h010, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL txf0_read_zero got=%h exp=0", v); end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) bus_wr(12'h0D0, $urandom);
            else osr_cycle(1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom), 4'($urandom));
            checks++;
            if ({osr_data, osr_valid} !== {m_od, m_ov}) begin
                failures++; $display("FAIL osr_random iter=%0d dir=%0b got=%h exp=%h", i, m_shift[19], {osr_data, osr_valid}, {m_od, m_ov});
            end
        end
    endtask

    task automatic test_load_wins;
        bus_wr(12'h0D0, 32'h0);
        bus_wr(12'h010, 32'h81);
        osr_cycle(1'b1, 32'h3C, 1'b1, 4'd1);
        checks++; if ({osr_data, osr_valid} !== 16'h3CFF) begin failures++; $display("FAIL osr_load_wins got=%h exp=3CFF", {osr_data, osr_valid}); end
        osr_cycle(1'b0, 32'h0, 1'b1, 4'd1);
        checks++; if ({osr_data, osr_valid} !== 16'h78FE) begin failures++; $display("FAIL osr_shift_left1 got=%h exp=78FE", {osr_data, osr_valid}); end
        osr_cycle(1'b0, 32'h0, 1'b1, 4'd0);
        checks++; if ({osr_data, osr_valid} !== 16'h78FE) begin failures++; $display("FAIL osr_amnt0_noop got=%h exp=78FE", {osr_data, osr_valid}); end
    endtask

    task automatic test_addr_instr;
        logic [31:0] v;
        pc = 5'd7;
        bus_rd(12'h0D4, v);
        checks++; if (v !== 32'h7) begin failures++; $display("FAIL sm0_addr got=%h exp=7", v); end
        @(negedge clk);
        bus.sel = 1'b1; bus.RW = 1'b1; bus.addr = 12'h0D8; bus.wdata = $urandom;
        #1;
        checks++; if (instr_wr !== 1'b1) begin failures++; $display("FAIL instr_wr_pulse got=%b exp=1", instr_wr); end
        bus.RW = 1'b0;
        #1;
        checks++; if (instr_wr !== 1'b0 || bus.rdata !== 32'h0) begin failures++; $display("FAIL instr_read got=%b/%h exp=0/0", instr_wr, bus.rdata); end
        bus.RW = 1'b1; bus.addr = 12'h0D4;
        #1;
        checks++; if (instr_wr !== 1'b0) begin failures++; $display("FAIL instr_wr_other_addr got=%b exp=0", instr_wr); end
        bus.sel = 1'b0; bus.RW = 1'b0;
    endtask

    task automatic test_regs_random;
        logic [11:0] al [10];
        logic [11:0] a;
        logic [31:0] v;
        al = '{12'h000, 12'h0C8, 12'h0CC, 12'h0D0, 12'h004, 12'h0DC, 12'h100, 12'h0C4, 12'h0D4, 12'h0D8};
        for (int i = 0; i < 30; i++) begin
            bus_wr(al[$urandom_range(0, 9)], $urandom);
            checks++;
            if ({sm_enable, clkdiv_int, clkdiv_frac, wrap_top, wrap_bottom, out_shiftdir, osr_data, osr_valid} !==
                {m_en, m_clkdiv[31:16], m_clkdiv[15:8], m_exec[16:12], m_exec[11:7], m_shift[19], m_od, m_ov}) begin
                failures++; $display("FAIL regs_outputs iter=%0d got=%h exp=%h", i,
                    {sm_enable, clkdiv_int, clkdiv_frac, wrap_top, wrap_bottom, out_shiftdir, osr_data, osr_valid},
                    {m_en, m_clkdiv[31:16], m_clkdiv[15:8], m_exec[16:12], m_exec[11:7], m_shift[19], m_od, m_ov});
            end
            pc = 5'($urandom);
            a = al[$urandom_range(0, 9)];
            bus_rd(a, v);
            checks++; if (v !== exp_read(a)) begin failures++; $display("FAIL regs_read addr=%h got=%h exp=%h", a, v, exp_read(a)); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        bus_wr(12'h000, 32'h1);
        bus_wr(12'h0C8, 32'h1234_5678);
        bus_wr(12'h0CC, 32'h0000_0F80);
        bus_wr(12'h0D0, 32'h0);
        bus_wr(12'h010, 32'h5A);
        bus_wr(12'h048, 32'hBEEF);
        @(negedge clk); pc = 5'd0; rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        checks++;
        if ({sm_enable, clkdiv_int, wrap_top, wrap_bottom, imem_rdata, osr_data} !== {1'b1, 16'h1234, 5'd0, 5'd31, 16'hBEEF, 8'h5A}) begin
            failures++; $display("FAIL pre_reset_state got=%h exp=%h",
                {sm_enable, clkdiv_int, wrap_top, wrap_bottom, imem_rdata, osr_data}, {1'b1, 16'h1234, 5'd0, 5'd31, 16'hBEEF, 8'h5A});
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sm_enable, sm_restart, clkdiv_int, clkdiv_frac, wrap_top, wrap_bottom, out_shiftdir, imem_rdata, osr_data, osr_valid} !==
            {2'b00, 16'd1, 8'd0, 5'd31, 5'd0, 1'b1, 16'h0, 8'h0, 8'h0}) begin
            failures++; $display("FAIL async_reset_outputs got=%h exp=%h",
                {sm_enable, sm_restart, clkdiv_int, clkdiv_frac, wrap_top, wrap_bottom, out_shiftdir, imem_rdata, osr_data, osr_valid},
                {2'b00, 16'd1, 8'd0, 5'd31, 5'd0, 1'b1, 16'h0, 8'h0, 8'h0});
        end
        bus.sel = 1'b1; bus.RW = 1'b0; bus.addr = 12'h0C8;
        #1 v = bus.rdata;
        bus.sel = 1'b0;
        checks++; if (v !== 32'h0001_0000) begin failures++; $display("FAIL async_reset_clkdiv_read got=%h exp=%h", v, 32'h0001_0000); end
        model_reset();
        @(negedge clk) reset = 1'b1;
        bus_rd(12'h0CC, v);
        checks++; if (v !== 32'h0001_F000) begin failures++; $display("FAIL post_reset_execctrl got=%h exp=%h", v, 32'h0001_F000); end
    endtask

    initial begin
        bus.sel = 1'b0; bus.RW = 1'b0; bus.addr = '0; bus.wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_imem();
        test_ctrl();
        test_osr();
        test_load_wins();
        test_addr_instr();
        test_regs_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
